// File: rtl/alu_exec_seq_pkg.sv
// Shared ALUOp encodings and small helpers for the execute-stage ALU.
// The encodings mirror the ALU control decoder output and must not drift from it.
package alu_exec_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_OR   = 4'h7;
  localparam logic [3:0] ALU_AND  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_PASS = 4'hA;
  localparam logic [3:0] ALU_NOP  = 4'hB;

  // Comparison flags captured at accept, published when the result is.
  typedef struct packed {
    logic lt;
    logic ltu;
  } cmp_flags_t;

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic op_is_defined(input logic [3:0] op);
    return op <= ALU_NOP;
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative shifter: one bit per cycle, down-counter on the shift amount, done strobe
// asserted during the cycle whose edge performs the final shift.
module alu_shift_iter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               kill,
  input  logic               left,
  input  logic               arith,
  input  logic [XLEN-1:0]    data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [XLEN-1:0]    data_out
);

  logic [XLEN-1:0]    sh_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               active_q;
  logic               left_q;
  logic               arith_q;
  logic [XLEN-1:0]    shifted;

  // Arithmetic right shifts keep replicating the MSB, which is the sign captured at load.
  always_comb begin
    shifted = sh_q;
    if (left_q) begin
      shifted = {sh_q[XLEN-2:0], 1'b0};
    end else begin
      shifted = {arith_q & sh_q[XLEN-1], sh_q[XLEN-1:1]};
    end
  end

  assign done     = active_q && (cnt_q == SHAMT_W'(1));
  assign data_out = shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
    end else if (kill) begin
      active_q <= 1'b0;
    end else if (start) begin
      sh_q     <= data_in;
      cnt_q    <= shamt;
      left_q   <= left;
      arith_q  <= arith;
      active_q <= (shamt != '0);
    end else if (active_q) begin
      sh_q  <= shifted;
      cnt_q <= cnt_q - SHAMT_W'(1);
      if (done) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Execute-stage ALU with valid/ready request and result handshakes; shifts run
// iteratively, everything else completes in one cycle.
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu,
  output logic            op_err,
  output logic            busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         state_q;
  logic [XLEN-1:0]    result_q;
  logic               zero_q;
  logic               lt_q;
  logic               ltu_q;
  logic               op_err_q;
  cmp_flags_t         pend_q;

  logic               accept;
  logic               is_shift;
  logic [SHAMT_W-1:0] shamt;
  logic               lt_now;
  logic               ltu_now;
  logic [XLEN-1:0]    alu_res;
  logic               sh_done;
  logic [XLEN-1:0]    sh_result;

  assign in_ready  = (state_q == ST_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign op_err    = op_err_q;

  assign is_shift = op_is_shift(alu_op);
  assign shamt    = src_b[SHAMT_W-1:0];
  assign lt_now   = $signed(src_a) < $signed(src_b);
  assign ltu_now  = src_a < src_b;

  // Shift ops yield src_a here so a zero shift amount completes in one cycle like any other op.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  alu_res = src_a;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_now};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, ltu_now};
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_PASS: alu_res = src_b;
      ALU_NOP:  alu_res = '0;
      default:  alu_res = '0;
    endcase
  end

  alu_shift_iter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && is_shift),
    .kill     (flush),
    .left     (alu_op == ALU_SLL),
    .arith    (alu_op == ALU_SRA),
    .data_in  (src_a),
    .shamt    (shamt),
    .done     (sh_done),
    .data_out (sh_result)
  );

  // Visible result/flags only change on entry to DONE, so a flush leaves the last ones intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
      op_err_q <= 1'b0;
      pend_q   <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              pend_q  <= '{lt: lt_now, ltu: ltu_now};
              state_q <= ST_SHIFT;
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              lt_q     <= lt_now;
              ltu_q    <= ltu_now;
              op_err_q <= !op_is_defined(alu_op);
              state_q  <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            result_q <= sh_result;
            zero_q   <= (sh_result == '0);
            lt_q     <= pend_q.lt;
            ltu_q    <= pend_q.ltu;
            op_err_q <= 1'b0;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
